operand_fetch_stage: RTL and testbench

- Pipeline stage directly upstream of ArithmeticLogicUnit.
- Decodes a 16-bit instruction word and reads the register file and flags register.
- Registers Operation/InSrc/InDest/InImm/InFlags toward the ALU under a valid/ready handshake.
- Accepts the writeback of the ALU result (OutDest/OutFlags) and enforces one outstanding instruction, so every ALU op sees up-to-date operands and Carry.

---
 rtl/operand_fetch_stage_pkg.sv | 65 ++++++
 rtl/operand_fetch_stage_register_file.sv | 34 +++
 rtl/operand_fetch_stage.sv | 145 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Instruction-set definitions shared by the operand fetch stage and the ALU:
// field layout, operation encoding, flags and the decoded-instruction view.
package InstructionSetPkg;

  localparam int NumRegs        = 8;
  localparam int RegAddrWidth   = $clog2(NumRegs);
  localparam int DataWidth      = 16;
  localparam int OpcodeWidth    = 4;
  localparam int ImmediateWidth = 6;
  localparam int InstrWidth     = 16;

  localparam int OpcodeLsb = 12;
  localparam int RdLsb     = 9;
  localparam int RsLsb     = 6;
  localparam int ImmLsb    = 0;

  typedef enum logic [OpcodeWidth-1:0] {
    MOVE = 4'd0,
    ADD  = 4'd1,
    ADC  = 4'd2,
    SUB  = 4'd3,
    SBC  = 4'd4,
    AND  = 4'd5,
    OR   = 4'd6,
    XOR  = 4'd7,
    NOT  = 4'd8,
    SHL  = 4'd9,
    SHR  = 4'd10,
    ROL  = 4'd11,
    ROR  = 4'd12,
    LIL  = 4'd13,
    LIU  = 4'd14
  } eOperation;

  // Opcodes at or above this value have no eOperation member.
  localparam int NumOperations = 15;

  typedef struct packed {
    logic Negative;
    logic Zero;
    logic Overflow;
    logic Carry;
  } sFlags;

  typedef struct packed {
    logic [OpcodeWidth-1:0]    opcode;
    logic [RegAddrWidth-1:0]   rd;
    logic [RegAddrWidth-1:0]   rs;
    logic [ImmediateWidth-1:0] imm;
  } sDecodedInstr;

  function automatic sDecodedInstr decode(input logic [InstrWidth-1:0] word);
    sDecodedInstr d;
    d.opcode = word[OpcodeLsb +: OpcodeWidth];
    d.rd     = word[RdLsb +: RegAddrWidth];
    d.rs     = word[RsLsb +: RegAddrWidth];
    d.imm    = word[ImmLsb +: ImmediateWidth];
    return d;
  endfunction

  function automatic logic is_legal(input logic [OpcodeWidth-1:0] opcode);
    return opcode < OpcodeWidth'(NumOperations);
  endfunction

endpackage

// File: rtl/operand_fetch_stage_register_file.sv
// General register file: two asynchronous read ports, one synchronous write
// port, synchronous active-high reset clearing every entry.
module register_file #(
  parameter int Depth = 8,
  parameter int Width = 16,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WrEnable,
  input  logic [AddrWidth-1:0] WrAddr,
  input  logic [Width-1:0]     WrData,
  input  logic [AddrWidth-1:0] RdAddrA,
  output logic [Width-1:0]     RdDataA,
  input  logic [AddrWidth-1:0] RdAddrB,
  output logic [Width-1:0]     RdDataB
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (WrEnable) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  assign RdDataA = mem_q[RdAddrA];
  assign RdDataB = mem_q[RdAddrB];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage feeding the ALU; one instruction outstanding until its
// writeback. Define OPERAND_BYPASS_EN to forward writeback data into issue.
module operand_fetch_stage
  import InstructionSetPkg::*;
(
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      InstrValid,
  input  logic [InstrWidth-1:0]     Instruction,
  output logic                      InstrReady,
  output logic                      AluValid,
  input  logic                      AluReady,
  output eOperation                 Operation,
  output logic [DataWidth-1:0]      InSrc,
  output logic [DataWidth-1:0]      InDest,
  output logic [ImmediateWidth-1:0] InImm,
  output sFlags                     InFlags,
  output logic [RegAddrWidth-1:0]   DestReg,
  input  logic                      WbEnable,
  input  logic [RegAddrWidth-1:0]   WbReg,
  input  logic [DataWidth-1:0]      WbData,
  input  sFlags                     WbFlags,
  output logic                      IllegalOp
);

  sDecodedInstr              instr;
  logic [DataWidth-1:0]      rf_src, rf_dest;
  logic [DataWidth-1:0]      src_operand, dest_operand;
  sFlags                     flags_operand;
  logic                      accept, issue;

  logic                      pending_q, pending_d;
  logic                      alu_valid_q, alu_valid_d;
  logic                      illegal_q, illegal_d;
  sFlags                     flags_q, flags_d;
  eOperation                 op_q, op_d;
  logic [DataWidth-1:0]      src_q, src_d;
  logic [DataWidth-1:0]      dest_q, dest_d;
  logic [ImmediateWidth-1:0] imm_q, imm_d;
  sFlags                     in_flags_q, in_flags_d;
  logic [RegAddrWidth-1:0]   dreg_q, dreg_d;

  assign instr = decode(Instruction);

  register_file #(
    .Depth (NumRegs),
    .Width (DataWidth)
  ) u_register_file (
    .Clock    (Clock),
    .Reset    (Reset),
    .WrEnable (WbEnable),
    .WrAddr   (WbReg),
    .WrData   (WbData),
    .RdAddrA  (instr.rs),
    .RdDataA  (rf_src),
    .RdAddrB  (instr.rd),
    .RdDataB  (rf_dest)
  );

`ifdef OPERAND_BYPASS_EN
  // Issuing over a writeback is refused while a stalled bundle must stay stable.
  logic bypass_ok;
  assign bypass_ok     = WbEnable && !(alu_valid_q && !AluReady);
  assign InstrReady    = !pending_q || bypass_ok;
  assign src_operand   = (WbEnable && (WbReg == instr.rs)) ? WbData : rf_src;
  assign dest_operand  = (WbEnable && (WbReg == instr.rd)) ? WbData : rf_dest;
  assign flags_operand = WbEnable ? WbFlags : flags_q;
`else
  assign InstrReady    = !pending_q;
  assign src_operand   = rf_src;
  assign dest_operand  = rf_dest;
  assign flags_operand = flags_q;
`endif

  assign accept = InstrValid && InstrReady;
  assign issue  = accept && is_legal(instr.opcode);

  always_comb begin
    pending_d   = pending_q;
    alu_valid_d = alu_valid_q;
    op_d        = op_q;
    src_d       = src_q;
    dest_d      = dest_q;
    imm_d       = imm_q;
    in_flags_d  = in_flags_q;
    dreg_d      = dreg_q;
    flags_d     = WbEnable ? WbFlags : flags_q;
    illegal_d   = accept && !is_legal(instr.opcode);

    // Issue takes priority so accept and writeback on one edge keep Pending set.
    if (issue) begin
      pending_d = 1'b1;
    end else if (WbEnable) begin
      pending_d = 1'b0;
    end

    if (issue) begin
      alu_valid_d = 1'b1;
      op_d        = eOperation'(instr.opcode);
      src_d       = src_operand;
      dest_d      = dest_operand;
      imm_d       = instr.imm;
      in_flags_d  = flags_operand;
      dreg_d      = instr.rd;
    end else if (AluReady) begin
      alu_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending_q   <= 1'b0;
      alu_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      flags_q     <= '0;
      op_q        <= MOVE;
      src_q       <= '0;
      dest_q      <= '0;
      imm_q       <= '0;
      in_flags_q  <= '0;
      dreg_q      <= '0;
    end else begin
      pending_q   <= pending_d;
      alu_valid_q <= alu_valid_d;
      illegal_q   <= illegal_d;
      flags_q     <= flags_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      imm_q       <= imm_d;
      in_flags_q  <= in_flags_d;
      dreg_q      <= dreg_d;
    end
  end

  assign AluValid  = alu_valid_q;
  assign Operation = op_q;
  assign InSrc     = src_q;
  assign InDest    = dest_q;
  assign InImm     = imm_q;
  assign InFlags   = in_flags_q;
  assign DestReg   = dreg_q;
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Randomized and directed bench for operand_fetch_stage against a
// transaction-level model; honours OPERAND_BYPASS_EN like the design.
module tb_operand_fetch_stage;
  import InstructionSetPkg::*;

`ifdef OPERAND_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instruction;
  logic        InstrReady;
  logic        AluValid;
  logic        AluReady;
  eOperation   Operation;
  logic [15:0] InSrc;
  logic [15:0] InDest;
  logic [5:0]  InImm;
  sFlags       InFlags;
  logic [2:0]  DestReg;
  logic        WbEnable;
  logic [2:0]  WbReg;
  logic [15:0] WbData;
  sFlags       WbFlags;
  logic        IllegalOp;

  operand_fetch_stage dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .InstrValid  (InstrValid),
    .Instruction (Instruction),
    .InstrReady  (InstrReady),
    .AluValid    (AluValid),
    .AluReady    (AluReady),
    .Operation   (Operation),
    .InSrc       (InSrc),
    .InDest      (InDest),
    .InImm       (InImm),
    .InFlags     (InFlags),
    .DestReg     (DestReg),
    .WbEnable    (WbEnable),
    .WbReg       (WbReg),
    .WbData      (WbData),
    .WbFlags     (WbFlags),
    .IllegalOp   (IllegalOp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural registers, flags, outstanding instruction
  // and the bundle the ALU should be seeing.
  logic [15:0] m_reg [8];
  logic [3:0]  m_flags;
  bit          m_pend;
  bit          m_av;
  bit          m_ill;
  logic [3:0]  m_op;
  logic [15:0] m_src;
  logic [15:0] m_dst;
  logic [5:0]  m_imm;
  logic [3:0]  m_fl;
  logic [2:0]  m_dreg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic bit m_ready(input bit wb, input bit ardy);
    return !m_pend || (Bypass && wb && !(m_av && !ardy));
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int imm);
    logic [15:0] w;
    w = {4'(op), 3'(rd), 3'(rs), 6'(imm)};
    return w;
  endfunction

  task automatic step(input bit rst, input bit iv, input logic [15:0] ins, input bit ardy,
                      input bit wb, input logic [2:0] wr, input logic [15:0] wd,
                      input logic [3:0] wf);
    bit acc;
    bit legal;
    logic [2:0] rd;
    logic [2:0] rs;
    Reset       = rst;
    InstrValid  = iv;
    Instruction = ins;
    AluReady    = ardy;
    WbEnable    = wb;
    WbReg       = wr;
    WbData      = wd;
    WbFlags     = sFlags'(wf);
    #1;
    if (!rst) check_eq("instr_ready", 32'(InstrReady), 32'(m_ready(wb, ardy)));
    @(posedge Clock);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_flags = '0; m_pend = 0; m_av = 0; m_ill = 0;
      m_op = '0; m_src = '0; m_dst = '0; m_imm = '0; m_fl = '0; m_dreg = '0;
    end else begin
      acc   = iv && m_ready(wb, ardy);
      legal = int'(ins[15:12]) < 15;
      rd    = ins[11:9];
      rs    = ins[8:6];
      if (acc && legal) begin
        m_op   = ins[15:12];
        m_src  = (Bypass && wb && wr == rs) ? wd : m_reg[rs];
        m_dst  = (Bypass && wb && wr == rd) ? wd : m_reg[rd];
        m_imm  = ins[5:0];
        m_fl   = (Bypass && wb) ? wf : m_flags;
        m_dreg = rd;
        m_av   = 1;
        m_pend = 1;
      end else begin
        if (ardy) m_av = 0;
        if (wb) m_pend = 0;
      end
      m_ill = acc && !legal;
      if (wb) begin
        m_reg[wr] = wd;
        m_flags   = wf;
      end
    end
    @(negedge Clock);
    check_eq("alu_valid", 32'(AluValid), 32'(m_av));
    check_eq("illegal_op", 32'(IllegalOp), 32'(m_ill));
    check_eq("operation", 32'(Operation), 32'(m_op));
    check_eq("in_src", 32'(InSrc), 32'(m_src));
    check_eq("in_dest", 32'(InDest), 32'(m_dst));
    check_eq("in_imm", 32'(InImm), 32'(m_imm));
    check_eq("in_flags", 32'(InFlags), 32'(m_fl));
    check_eq("dest_reg", 32'(DestReg), 32'(m_dreg));
    $display("step rst=%0b iv=%0b ins=%h ardy=%0b wb=%0b r%0d=%h -> av=%0b op=%0d src=%h dst=%h fl=%h ill=%0b",
             rst, iv, ins, ardy, wb, wr, wd, AluValid, Operation, InSrc, InDest, InFlags, IllegalOp);
  endtask

  task automatic idle(input bit ardy);
    step(0, 0, 16'h0, ardy, 0, 3'd0, 16'h0, 4'h0);
  endtask

  // Let the bundle be consumed, then write back its destination.
  task automatic drain();
    for (int i = 0; i < 10 && m_pend; i++) begin
      if (m_av) idle(1);
      else step(0, 0, 16'h0, 1, 1, m_dreg, 16'($urandom), 4'($urandom));
    end
    check_eq("drain_timeout", 32'(m_pend), 32'(0));
  endtask

  initial begin
    logic [15:0] ins;
    Reset = 1; InstrValid = 0; Instruction = '0; AluReady = 0;
    WbEnable = 0; WbReg = '0; WbData = '0; WbFlags = '0;
    @(negedge Clock);
    step(1, 0, 16'h0, 0, 0, 3'd0, 16'h0, 4'h0);
    step(1, 0, 16'h0, 0, 0, 3'd0, 16'h0, 4'h0);

    // Reset then idle
    idle(0);
    check_eq("rst_valid", 32'(AluValid), 32'(0));
    check_eq("rst_ready", 32'(InstrReady), 32'(1));
    check_eq("rst_src", 32'(InSrc), 32'(0));
    check_eq("rst_flags", 32'(InFlags), 32'(0));

    // ADC R1, R2 after writebacks
    step(0, 0, 16'h0, 0, 1, 3'd1, 16'h7FFF, 4'h0);
    step(0, 0, 16'h0, 0, 1, 3'd2, 16'h0001, 4'h0);
    step(0, 1, mk(ADC, 1, 2, 6'h2A), 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("adc_valid", 32'(AluValid), 32'(1));
    check_eq("adc_dest", 32'(InDest), 32'h7FFF);
    check_eq("adc_src", 32'(InSrc), 32'h0001);
    check_eq("adc_dreg", 32'(DestReg), 32'(1));
    check_eq("adc_carry", 32'(InFlags.Carry), 32'(0));
    check_eq("adc_imm", 32'(InImm), 32'h2A);

    // Stall: outputs hold, second instruction waits for writeback
    ins = mk(MOVE, 3, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, ins, 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("hold_dest", 32'(InDest), 32'h7FFF);
    check_eq("hold_ready", 32'(InstrReady), 32'(0));
    step(0, 1, ins, 1, 0, 3'd0, 16'h0, 4'h0);
    check_eq("no_issue_before_wb", 32'(AluValid), 32'(0));
    step(0, 1, ins, 1, 1, 3'd1, 16'h1234, 4'h2);
    step(0, 1, ins, 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("second_issued", 32'(AluValid), 32'(1));
    check_eq("second_src", 32'(InSrc), 32'h1234);
    drain();

    // Writeback of R1 coincides with ROL R1, R1 being offered
    step(0, 1, mk(MOVE, 4, 5, 0), 1, 0, 3'd0, 16'h0, 4'h0);
    idle(1);
    ins = mk(ROL, 1, 1, 0);
    step(0, 1, ins, 0, 1, 3'd1, 16'h8000, 4'h1);
    step(0, 1, ins, 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("rol_src", 32'(InSrc), 32'h8000);
    check_eq("rol_dest", 32'(InDest), 32'h8000);
    check_eq("rol_carry", 32'(InFlags.Carry), 32'(1));
    check_eq("rol_valid", 32'(AluValid), 32'(1));
    drain();

    // Illegal opcode, then immediate accept
    step(0, 1, 16'hF123, 1, 0, 3'd0, 16'h0, 4'h0);
    check_eq("ill_pulse", 32'(IllegalOp), 32'(1));
    check_eq("ill_valid", 32'(AluValid), 32'(0));
    step(0, 1, mk(MOVE, 0, 0, 0), 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("ill_pulse_end", 32'(IllegalOp), 32'(0));
    check_eq("after_ill_valid", 32'(AluValid), 32'(1));

    // Reset while valid and pending, with a writeback in flight
    step(1, 1, mk(ADD, 1, 2, 0), 0, 1, 3'd2, 16'hBEEF, 4'hF);
    check_eq("rst_mid_valid", 32'(AluValid), 32'(0));
    check_eq("rst_mid_dest", 32'(InDest), 32'(0));
    step(0, 1, mk(MOVE, 1, 2, 0), 0, 0, 3'd0, 16'h0, 4'h0);
    check_eq("rst_r1", 32'(InDest), 32'(0));
    check_eq("rst_r2", 32'(InSrc), 32'(0));
    drain();

    // Randomized traffic with the bench acting as ALU
    for (int n = 0; n < 400; n++) begin
      bit iv, ardy, wb;
      logic [2:0] wr;
      logic [3:0] op;
      iv   = ($urandom_range(0, 9) < 7);
      ardy = ($urandom_range(0, 3) != 0);
      op   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      ins  = {op, 12'($urandom)};
      wb   = 0;
      wr   = 3'($urandom);
      if (m_pend && !m_av && $urandom_range(0, 2) != 0) begin
        wb = 1;
        wr = m_dreg;
      end else if (!m_pend && $urandom_range(0, 3) == 0) begin
        wb = 1;
      end
      step(0, iv, ins, ardy, wb, wr, 16'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
